cast_flit_assembler: RTL and testbench
======================================

# cast_flit_assembler

Downstream consumer of the multicast receive FIFO (`fifo_inf`, width 8) in the network receive path. It pops narrow words whenever the FIFO is non-empty and packs `LANES` consecutive words into one wide flit. It presents each flit to the local sink on a valid/ready handshake, with a per-lane valid mask. An optional flush timer emits a partially filled flit when the FIFO stays empty too long.

## Interface
- `WIDTH`, 8: word width; must match the receive FIFO `width`.
- `LANES`, 4: words per flit, ≥2.
- `TIMEOUT`, 16: idle cycles before a partial flit is flushed (flush build only), ≥1.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `fifo_empty_i` in 1: receive FIFO empty flag.
- `fifo_data_i` in WIDTH: FIFO head word; first-word-fall-through, valid whenever `fifo_empty_i`=0.
- `fifo_read_o` out 1: pop strobe; the head word is consumed on the clock edge where it is 1.
- `flit_valid_o` out 1: flit available.
- `flit_ready_i` in 1: sink accepts the flit.
- `flit_data_o` out WIDTH*LANES: packed flit; lane k occupies bits [k*WIDTH +: WIDTH].
- `flit_mask_o` out LANES: bit k=1 means lane k holds a received word.

## Operation
- Two states: FILL (collecting words) and HOLD (flit presented).
- Lane index `idx` counts 0..LANES-1. Each popped word is written to lane `idx` and sets mask bit `idx`. Lane 0 receives the first word.
- `fifo_read_o` = ~rst_i & ~fifo_empty_i & (state==FILL | flit_ready_i). The output is combinational and needs no extra handshake cycle.
- FILL, pop with `idx`=LANES-1: go to HOLD and reset `idx` to 0.
- FILL, pop with `idx`<LANES-1: increment `idx`.
- HOLD: `flit_valid_o`=1. `flit_data_o` and `flit_mask_o` stay stable until accepted.
- HOLD with `flit_ready_i`=1 and no pop: return to FILL with data and mask cleared.
- HOLD with `flit_ready_i`=1 and a simultaneous pop: the popped word goes into lane 0 of the new flit (mask=1), `idx`=1, and the state is FILL. The old flit is accepted on the same edge.
- HOLD with `flit_ready_i`=0: no pop; the FIFO backs up.
- Unwritten lanes are always zero.
- Reset, including mid-flit: state FILL, `idx`=0, `flit_valid_o`=0, `flit_data_o`=0, `flit_mask_o`=0, timer 0. The partial flit is discarded. `fifo_read_o`=0 while `rst_i`=1.

## Timing
- Words popped on edges t..t+LANES-1 produce `flit_valid_o`=1 in the cycle after edge t+LANES-1.
- `flit_valid_o` is registered. `fifo_read_o` is combinational from `fifo_empty_i`, `flit_ready_i` and the state.
- Sustained throughput: one flit per LANES cycles when the FIFO never empties and the sink is always ready.
- Widths: `idx` is $clog2(LANES) bits. The flush timer is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT; it never wraps.

## Configuration
- Macro `CAST_ASM_FLUSH_EN`.
- Defined:
  - In FILL with `idx`>0, the timer increments on every cycle without a pop and clears on every pop.
  - When the timer reaches TIMEOUT, go to HOLD with the partial mask and `idx`=0; the timer clears.
  - A pop on the same cycle as the timeout takes priority: the word is stored and the timer clears.
- Not defined: no timer logic. A partial flit waits indefinitely for further words.

## Structure
- Shared package `cast_pkg` holds:
  - the state enum `cast_asm_state_e` {FILL, HOLD};
  - a `CAST_WORD_W` default constant (8), shared with the receive FIFO instance.
- Sub-module `cast_flush_timer` (clk_i, rst_i, clear, tick, expired) contains the saturating counter. It is instantiated only under `CAST_ASM_FLUSH_EN`.

## Test plan
- Reset mid-flit: pop 2 words, assert `rst_i` for 1 cycle → all outputs 0; the next 4 words 0x11..0x14 yield data 0x14131211, mask 0xF.
- Continuous stream: FIFO holds 0x01..0x08, `flit_ready_i`=1 → flits 0x04030201 then 0x08070605, mask 0xF. `fifo_read_o` stays high for 8 consecutive cycles.
- Backpressure: hold `flit_ready_i`=0 for 10 cycles with a full flit presented → `fifo_read_o`=0 and data stable throughout. Ready rises → accept, with a simultaneous pop into lane 0.
- Flush (macro on, TIMEOUT=16): pop 0xA1, 0xA2, then FIFO empty → after 16 idle cycles a flit 0x0000A2A1, mask 0x3.
- Flush race (macro on): a word arrives exactly on the timeout cycle → it is stored in lane 2 and no flush occurs. With the macro off, the 2-word partial never emits.

Source files
------------

// File: rtl/cast_pkg.sv
// Shared types and constants for the multicast receive path.
package cast_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } cast_asm_state_e;

    // Word width of the multicast receive FIFO instance.
    localparam int CAST_WORD_W = 8;

endpackage

// File: rtl/cast_flush_timer.sv
// Saturating idle counter for the partial-flit flush; expired_o marks the tick that reaches TIMEOUT.
module cast_flush_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expired_o = tick_i & (count_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cast_flit_assembler.sv
// Packs LANES FIFO words into one flit with a lane mask and valid/ready output.
// Define CAST_ASM_FLUSH_EN to flush partial flits after TIMEOUT idle cycles.
module cast_flit_assembler
    import cast_pkg::*;
#(
    parameter int WIDTH   = CAST_WORD_W,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fifo_empty_i,
    input  logic [WIDTH-1:0]       fifo_data_i,
    output logic                   fifo_read_o,
    output logic                   flit_valid_o,
    input  logic                   flit_ready_i,
    output logic [WIDTH*LANES-1:0] flit_data_o,
    output logic [LANES-1:0]       flit_mask_o
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    cast_asm_state_e        state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WIDTH*LANES-1:0] data_q, data_d;
    logic [LANES-1:0]       mask_q, mask_d;

    // A held flit only frees its slot on the edge it is accepted, so pops in HOLD need ready.
    assign fifo_read_o = ~rst_i & ~fifo_empty_i & ((state_q == FILL) | flit_ready_i);

`ifdef CAST_ASM_FLUSH_EN
    logic flush_tick;
    logic flush_clear;
    logic flush_expired;

    assign flush_tick  = (state_q == FILL) && (idx_q != '0) && !fifo_read_o;
    assign flush_clear = !flush_tick || flush_expired;

    cast_flush_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_flush_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (flush_clear),
        .tick_i   (flush_tick),
        .expired_o(flush_expired)
    );
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        unique case (state_q)
            FILL: begin
                if (fifo_read_o) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            data_d[k*WIDTH +: WIDTH] = fifo_data_i;
                            mask_d[k]                = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = HOLD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef CAST_ASM_FLUSH_EN
                else if (flush_expired) begin
                    state_d = HOLD;
                    idx_d   = '0;
                end
`endif
            end
            HOLD: begin
                if (flit_ready_i) begin
                    state_d = FILL;
                    idx_d   = '0;
                    data_d  = '0;
                    mask_d  = '0;
                    if (fifo_read_o) begin
                        data_d[WIDTH-1:0] = fifo_data_i;
                        mask_d[0]         = 1'b1;
                        idx_d             = IDX_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign flit_valid_o = (state_q == HOLD);
    assign flit_data_o  = data_q;
    assign flit_mask_o  = mask_q;

endmodule

// File: tb/tb_cast_flit_assembler.sv
// Directed bench for cast_flit_assembler; flush checks follow CAST_ASM_FLUSH_EN.
module tb_cast_flit_assembler;

    localparam int WIDTH   = 8;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   fifo_empty_i;
    logic [WIDTH-1:0]       fifo_data_i;
    logic                   fifo_read_o;
    logic                   flit_valid_o;
    logic                   flit_ready_i;
    logic [WIDTH*LANES-1:0] flit_data_o;
    logic [LANES-1:0]       flit_mask_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] fifo_q[$];
    logic       last_pop;

    always #5 clk_i = ~clk_i;

    cast_flit_assembler #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_read_o (fifo_read_o),
        .flit_valid_o(flit_valid_o),
        .flit_ready_i(flit_ready_i),
        .flit_data_o (flit_data_o),
        .flit_mask_o (flit_mask_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // One clock: sample the pop strobe before the edge, retire the head word, re-drive after.
    task automatic cycle();
        #1;
        last_pop = fifo_read_o;
        @(posedge clk_i);
        if (last_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        #1;
        drive_fifo();
    endtask

    initial begin
        int reads;
        int seen;
        logic [31:0] held;

        // Reset state, with a word waiting that must not be popped.
        rst_i        = 1'b1;
        flit_ready_i = 1'b0;
        fifo_q.push_back(8'h99);
        drive_fifo();
        cycle();
        cycle();
        check("rst_read", fifo_read_o, 0);
        check("rst_valid", flit_valid_o, 0);
        check("rst_data", flit_data_o, 0);
        check("rst_mask", flit_mask_o, 0);
        fifo_q.delete();
        drive_fifo();

        // Reset mid-flit discards the partial flit.
        rst_i = 1'b0;
        fifo_q.push_back(8'h21);
        fifo_q.push_back(8'h22);
        drive_fifo();
        cycle();
        cycle();
        check("partial_mask", flit_mask_o, 32'h3);
        check("partial_data", flit_data_o, 32'h0000_2221);
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h11 + i));
        drive_fifo();
        #1;
        check("read_in_rst", fifo_read_o, 0);
        cycle();
        check("midrst_valid", flit_valid_o, 0);
        check("midrst_data", flit_data_o, 0);
        check("midrst_mask", flit_mask_o, 0);
        rst_i = 1'b0;
        cycle();
        cycle();
        cycle();
        check("three_words_valid", flit_valid_o, 0);
        cycle();
        check("after_rst_valid", flit_valid_o, 1);
        check("after_rst_data", flit_data_o, 32'h1413_1211);
        check("after_rst_mask", flit_mask_o, 32'hF);
        flit_ready_i = 1'b1;
        cycle();
        check("accept_empty_valid", flit_valid_o, 0);
        check("accept_empty_mask", flit_mask_o, 0);

        // Continuous stream at full throughput.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        drive_fifo();
        reads = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_pop) reads++;
            if (i == 3) begin
                check("stream1_valid", flit_valid_o, 1);
                check("stream1_data", flit_data_o, 32'h0403_0201);
                check("stream1_mask", flit_mask_o, 32'hF);
            end
            if (i == 4) check("stream_refill_mask", flit_mask_o, 32'h1);
        end
        check("stream_reads", reads, 8);
        check("stream2_valid", flit_valid_o, 1);
        check("stream2_data", flit_data_o, 32'h0807_0605);
        check("stream2_mask", flit_mask_o, 32'hF);
        #1;
        check("stream_drained_read", fifo_read_o, 0);
        cycle();
        check("stream_accept_valid", flit_valid_o, 0);

        // Backpressure: a presented flit stays put and the FIFO is not popped.
        flit_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h31 + i));
        drive_fifo();
        for (int i = 0; i < 4; i++) cycle();
        held = flit_data_o;
        check("bp_full_data", held, 32'h3433_3231);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_read", last_pop, 0);
            check("bp_data", flit_data_o, 32'h3433_3231);
            check("bp_valid", flit_valid_o, 1);
        end
        flit_ready_i = 1'b1;
        #1;
        check("bp_release_read", fifo_read_o, 1);
        cycle();
        check("bp_accept_valid", flit_valid_o, 0);
        check("bp_lane0_mask", flit_mask_o, 32'h1);
        check("bp_lane0_data", flit_data_o, 32'h0000_0035);
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'(8'h36 + i));
        drive_fifo();
        cycle();
        cycle();
        cycle();
        check("bp_next_data", flit_data_o, 32'h3837_3635);
        check("bp_next_valid", flit_valid_o, 1);
        cycle();
        check("bp_next_accept", flit_valid_o, 0);

`ifdef CAST_ASM_FLUSH_EN
        // Flush of a 2-word partial after TIMEOUT idle cycles.
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        drive_fifo();
        cycle();
        cycle();
        for (int i = 0; i < TIMEOUT - 1; i++) cycle();
        check("flush_early_valid", flit_valid_o, 0);
        cycle();
        check("flush_valid", flit_valid_o, 1);
        check("flush_data", flit_data_o, 32'h0000_A2A1);
        check("flush_mask", flit_mask_o, 32'h3);
        cycle();
        check("flush_accept", flit_valid_o, 0);

        // A word arriving on the timeout cycle wins over the flush.
        fifo_q.push_back(8'hB1);
        fifo_q.push_back(8'hB2);
        drive_fifo();
        cycle();
        cycle();
        for (int i = 0; i < TIMEOUT - 1; i++) cycle();
        fifo_q.push_back(8'hB3);
        drive_fifo();
        cycle();
        check("race_valid", flit_valid_o, 0);
        check("race_mask", flit_mask_o, 32'h7);
        check("race_data", flit_data_o, 32'h00B3_B2B1);
        fifo_q.push_back(8'hB4);
        drive_fifo();
        cycle();
        check("race_full_data", flit_data_o, 32'hB4B3_B2B1);
        check("race_full_valid", flit_valid_o, 1);
        cycle();
`else
        // Without the flush timer a partial flit waits indefinitely.
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        drive_fifo();
        cycle();
        cycle();
        seen = 0;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            cycle();
            if (flit_valid_o) seen++;
        end
        check("noflush_valid_seen", seen, 0);
        check("noflush_mask", flit_mask_o, 32'h3);
        check("noflush_data", flit_data_o, 32'h0000_A2A1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
